// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, Z-capture FSM states and the default word width.
package alu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_OR         = 5'd0;
  localparam logic [4:0] OP_AND        = 5'd1;
  localparam logic [4:0] OP_ADD        = 5'd2;
  localparam logic [4:0] OP_SUB        = 5'd3;
  localparam logic [4:0] OP_ADDU       = 5'd4;
  localparam logic [4:0] OP_MUL        = 5'd5;
  localparam logic [4:0] OP_LAST_LEGAL = 5'd5;

  typedef enum logic [1:0] {
    IDLE,
    PIPE,
    MULWAIT
  } state_t;

endpackage

// File: rtl/alu_z_capture_if.sv
// Control-unit side bundle of the Z capture stage.
// zero_flag/neg_flag exist only when ALU_Z_FLAGS_EN is defined.
interface alu_z_capture_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic                      start;
  logic [4:0]                op;
  logic [2*DATA_WIDTH-1:0]   alu_result;
  logic                      mul_done;
  logic                      ack;
  logic                      ZHiout;
  logic                      ZLoout;

  logic [2*DATA_WIDTH-1:0]   z_reg;
  logic [DATA_WIDTH-1:0]     bus_out;
  logic                      z_valid;
  logic                      busy;
  logic                      illegal_op;
  logic                      timeout_err;
`ifdef ALU_Z_FLAGS_EN
  logic                      zero_flag;
  logic                      neg_flag;
`endif

  // master is the control unit / ALU side, slave is the capture stage
  modport master (
`ifdef ALU_Z_FLAGS_EN
    input  zero_flag, neg_flag,
`endif
    output start, op, alu_result, mul_done, ack, ZHiout, ZLoout,
    input  z_reg, bus_out, z_valid, busy, illegal_op, timeout_err
  );

  modport slave (
`ifdef ALU_Z_FLAGS_EN
    output zero_flag, neg_flag,
`endif
    input  start, op, alu_result, mul_done, ack, ZHiout, ZLoout,
    output z_reg, bus_out, z_valid, busy, illegal_op, timeout_err
  );

endinterface

// File: rtl/z_bus_mux.sv
// Selects one word of the Z register onto the datapath bus; the low word wins when both enables are set.
module z_bus_mux
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [2*DATA_WIDTH-1:0] z_reg,
  input  logic                    hi_sel,
  input  logic                    lo_sel,
  output logic [DATA_WIDTH-1:0]   word_out
);

  always_comb begin
    word_out = '0;
    if (lo_sel) begin
      word_out = z_reg[DATA_WIDTH-1:0];
    end else if (hi_sel) begin
      word_out = z_reg[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

endmodule

// File: rtl/alu_z_capture.sv
// Captures the ALU's registered result into Z once stable and presents a Z word on the bus.
// Defining ALU_Z_FLAGS_EN adds registered zero/negative flags updated on every capture.
module alu_z_capture
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int MUL_TIMEOUT = 40
) (
  input logic            clk,
  input logic            reset,
  alu_z_capture_if.slave bus
);

  localparam int               CNT_W    = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        mul_cnt;
  logic [2*DATA_WIDTH-1:0] z_q;
  logic                    z_valid_q;
  logic                    illegal_q;
  logic                    timeout_q;

  logic                    accept;
  logic                    capture;
  logic                    illegal_hit;
  logic                    timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PIPE is the single settle cycle before capture; a multiply reaches it only once mul_done is seen
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    capture     = 1'b0;
    illegal_hit = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_OR, OP_AND, OP_ADD, OP_SUB, OP_ADDU: begin
              accept     = 1'b1;
              state_next = PIPE;
            end
            OP_MUL: begin
              accept     = 1'b1;
              state_next = MULWAIT;
            end
            default: begin
              illegal_hit = (bus.op > OP_LAST_LEGAL);
            end
          endcase
        end
      end
      PIPE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      MULWAIT: begin
        if (bus.mul_done) begin
          state_next = PIPE;
        end else if (mul_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (accept) begin
      mul_cnt <= '0;
    end else if (state == MULWAIT && !bus.mul_done && !timeout_hit) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // A capture on the same edge as ack leaves the new result valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= illegal_hit;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (capture) begin
        z_q       <= bus.alu_result;
        z_valid_q <= 1'b1;
      end else if (bus.ack) begin
        z_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_Z_FLAGS_EN
  logic [4:0] op_q;
  logic       zero_q;
  logic       neg_q;

  // A multiply result is signed over its full width, everything else over the low word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q <= bus.op;
      end
      if (capture) begin
        zero_q <= (bus.alu_result[DATA_WIDTH-1:0] == '0);
        neg_q  <= (op_q == OP_MUL) ? bus.alu_result[2*DATA_WIDTH-1]
                                   : bus.alu_result[DATA_WIDTH-1];
      end
    end
  end

  assign bus.zero_flag = zero_q;
  assign bus.neg_flag  = neg_q;
`endif

  assign bus.z_reg       = z_q;
  assign bus.z_valid     = z_valid_q;
  assign bus.busy        = (state != IDLE);
  assign bus.illegal_op  = illegal_q;
  assign bus.timeout_err = timeout_q;

  z_bus_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_z_bus_mux (
    .z_reg    (z_q),
    .hi_sel   (bus.ZHiout),
    .lo_sel   (bus.ZLoout),
    .word_out (bus.bus_out)
  );

endmodule

// File: tb/tb_alu_z_capture.sv
// Scoreboard bench for alu_z_capture: directed vectors queue expected captures, a monitor checks them.
module tb_alu_z_capture;
  import alu_pkg::*;

  localparam int DW          = 32;
  localparam int MUL_TIMEOUT = 40;

  typedef struct {
    logic [2*DW-1:0] z;
    logic            zero;
    logic            neg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  alu_z_capture_if #(.DATA_WIDTH(DW)) bus ();

  alu_z_capture #(
    .DATA_WIDTH  (DW),
    .MUL_TIMEOUT (MUL_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [63:0] z, input logic zero, input logic neg);
    exp_t e;
    e.z    = z;
    e.zero = zero;
    e.neg  = neg;
    exp_q.push_back(e);
  endtask

  // Start is raised just after one edge and sampled by the next; returns just after that sampling edge
  task automatic applyStimulus(input logic [4:0] op, input logic [63:0] result);
    bus.start      = 1'b1;
    bus.op         = op;
    bus.alu_result = result;
    step(1);
    bus.start      = 1'b0;
  endtask

  // Monitor: a capture shows up as z_valid rising or z_reg changing while valid
  initial begin
    logic            prev_valid;
    logic [2*DW-1:0] prev_z;
    exp_t            e;
    prev_valid = 1'b0;
    prev_z     = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.z_valid && (!prev_valid || bus.z_reg !== prev_z)) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected capture: got %0h, expected none", bus.z_reg);
        end else begin
          e = exp_q.pop_front();
          checkOutput("capture z_reg", bus.z_reg, e.z);
`ifdef ALU_Z_FLAGS_EN
          checkOutput("capture zero_flag", 64'(bus.zero_flag), 64'(e.zero));
          checkOutput("capture neg_flag", 64'(bus.neg_flag), 64'(e.neg));
`endif
        end
      end
      prev_valid = bus.z_valid;
      prev_z     = bus.z_reg;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit busy_ok;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.op         = '0;
    bus.alu_result = '0;
    bus.mul_done   = 1'b0;
    bus.ack        = 1'b0;
    bus.ZHiout     = 1'b0;
    bus.ZLoout     = 1'b0;
    step(2);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset z_reg", bus.z_reg, 64'd0);
    checkOutput("reset z_valid", 64'(bus.z_valid), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset illegal_op", 64'(bus.illegal_op), 64'd0);
    checkOutput("reset timeout_err", 64'(bus.timeout_err), 64'd0);
    checkOutput("reset bus_out", 64'(bus.bus_out), 64'd0);

    $display("[TB] ADD latency and word select");
    pushExpected(64'd7, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 64'd7);
    checkOutput("add busy after sample", 64'(bus.busy), 64'd1);
    checkOutput("add z_valid before capture", 64'(bus.z_valid), 64'd0);
    step(1);
    checkOutput("add z_valid after capture", 64'(bus.z_valid), 64'd1);
    checkOutput("add busy after capture", 64'(bus.busy), 64'd0);
    bus.ZLoout = 1'b1;
    #1 checkOutput("add bus_out lo", 64'(bus.bus_out), 64'h7);
    bus.ZLoout = 1'b0;
    bus.ZHiout = 1'b1;
    #1 checkOutput("add bus_out hi", 64'(bus.bus_out), 64'h0);
    bus.ZLoout = 1'b1;
    #1 checkOutput("add bus_out lo priority", 64'(bus.bus_out), 64'h7);
    bus.ZLoout = 1'b0;
    bus.ZHiout = 1'b0;
    bus.ack    = 1'b1;
    step(1);
    bus.ack = 1'b0;
    checkOutput("ack clears z_valid", 64'(bus.z_valid), 64'd0);

    $display("[TB] illegal opcode");
    applyStimulus(5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("illegal_op pulse", 64'(bus.illegal_op), 64'd1);
    checkOutput("illegal busy", 64'(bus.busy), 64'd0);
    step(1);
    checkOutput("illegal_op one cycle", 64'(bus.illegal_op), 64'd0);
    checkOutput("illegal no capture z_valid", 64'(bus.z_valid), 64'd0);
    checkOutput("illegal z_reg kept", bus.z_reg, 64'd7);

    $display("[TB] start during PIPE and ack on capture edge");
    pushExpected(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    applyStimulus(OP_AND, 64'h0123_4567_89AB_CDEF);
    bus.start = 1'b1;
    bus.op    = 5'd9;
    bus.ack   = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    checkOutput("capture beats ack", 64'(bus.z_valid), 64'd1);
    checkOutput("start in PIPE no flag", 64'(bus.illegal_op), 64'd0);
    checkOutput("start in PIPE ignored", 64'(bus.busy), 64'd0);

    $display("[TB] SUB accepted while z_valid");
    pushExpected(64'd0, 1'b1, 1'b0);
    applyStimulus(OP_SUB, 64'd0);
    checkOutput("old result still valid", 64'(bus.z_valid), 64'd1);
    checkOutput("old z_reg held", bus.z_reg, 64'h0123_4567_89AB_CDEF);
    step(1);
    checkOutput("sub z_valid", 64'(bus.z_valid), 64'd1);
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;

    $display("[TB] ADD negative low word");
    pushExpected(64'h0000_0000_8000_0000, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 64'h0000_0000_8000_0000);
    step(1);
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;

    $display("[TB] MUL with mul_done after 34 cycles");
    pushExpected(64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0);
    applyStimulus(OP_MUL, 64'd0);
    busy_ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step(1);
      if (!bus.busy || bus.z_valid) busy_ok = 1'b0;
    end
    checkOutput("mul busy while waiting", 64'(busy_ok), 64'd1);
    bus.mul_done   = 1'b1;
    bus.alu_result = 64'h0000_0001_FFFF_FFFE;
    step(1);
    bus.mul_done = 1'b0;
    checkOutput("mul busy after done", 64'(bus.busy), 64'd1);
    checkOutput("mul not yet captured", 64'(bus.z_valid), 64'd0);
    step(1);
    checkOutput("mul captured", 64'(bus.z_valid), 64'd1);
    checkOutput("mul busy cleared", 64'(bus.busy), 64'd0);
    bus.ZHiout = 1'b1;
    #1 checkOutput("mul bus_out hi", 64'(bus.bus_out), 64'h1);
    bus.ZHiout = 1'b0;
    bus.ZLoout = 1'b1;
    #1 checkOutput("mul bus_out lo", 64'(bus.bus_out), 64'hFFFF_FFFE);
    bus.ZLoout = 1'b0;

    $display("[TB] MUL timeout");
    applyStimulus(OP_MUL, 64'h5555_5555_5555_5555);
    step(MUL_TIMEOUT - 1);
    checkOutput("timeout not yet", 64'(bus.timeout_err), 64'd0);
    checkOutput("busy before timeout", 64'(bus.busy), 64'd1);
    step(1);
    checkOutput("timeout_err set", 64'(bus.timeout_err), 64'd1);
    checkOutput("busy after timeout", 64'(bus.busy), 64'd0);
    checkOutput("timeout z_valid kept", 64'(bus.z_valid), 64'd1);
    checkOutput("timeout z_reg kept", bus.z_reg, 64'h0000_0001_FFFF_FFFE);
    step(1);
    checkOutput("timeout_err sticky", 64'(bus.timeout_err), 64'd1);

    $display("[TB] restart MUL then async reset");
    applyStimulus(OP_MUL, 64'h5555_5555_5555_5555);
    checkOutput("second mul accepted", 64'(bus.busy), 64'd1);
    step(3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset z_reg", bus.z_reg, 64'd0);
    checkOutput("async reset z_valid", 64'(bus.z_valid), 64'd0);
    checkOutput("async reset busy", 64'(bus.busy), 64'd0);
    checkOutput("async reset timeout_err", 64'(bus.timeout_err), 64'd0);
`ifdef ALU_Z_FLAGS_EN
    checkOutput("async reset zero_flag", 64'(bus.zero_flag), 64'd0);
    checkOutput("async reset neg_flag", 64'(bus.neg_flag), 64'd0);
`endif
    step(1);
    reset = 1'b0;

    $display("[TB] ADDU after reset");
    pushExpected(64'h0000_0002_0000_0000, 1'b1, 1'b0);
    applyStimulus(OP_ADDU, 64'h0000_0002_0000_0000);
    step(1);
    checkOutput("addu z_valid", 64'(bus.z_valid), 64'd1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1);
    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
